multicycle_sequencer: RTL
=========================

// Module: multicycle_sequencer
// PURPOSE
// Parametrised multi-cycle control sequencer; replaces the free-running progress_ready/PC logic in cpu.
// Owns the PC and steps each instruction through FETCH/EXECUTE/MEM/WRITEBACK.
// Uses valid/ready handshakes to instruction and data memory, so memories may stall.
// Adds traps (illegal opcode, misaligned target), halt on environment instructions, and a retire counter.
// PARAMETERS
// XLEN          32        datapath/address width
// RESET_VECTOR  'h0       PC value loaded on reset
// TRAP_VECTOR   'h100     PC value loaded on any trap
// COUNT_W       32        retire counter width
// PORTS
// clk             in   1     clock
// rst             in   1     synchronous, active-high reset
// imem_req_valid  out  1     fetch request valid
// imem_req_ready  in   1     imem accepts request
// imem_addr       out  XLEN  fetch address (= pc)
// imem_rsp_valid  in   1     fetched instruction present on imem data bus
// instr_latch_en  out  1     1-cycle pulse: external instruction register captures imem data
// opcode_valid    in   1     decoder: legal opcode (sampled in EXECUTE)
// is_load         in   1     decoder class flag
// is_store        in   1     decoder class flag
// is_branch       in   1     decoder class flag
// is_jump         in   1     decoder: jal or jalr
// is_env          in   1     decoder: ecall/ebreak
// branch_taken    in   1     branch comparator result, valid in WRITEBACK
// jump_target     in   XLEN  computed branch/jump target, valid in WRITEBACK
// dmem_req_valid  out  1     load/store request valid
// dmem_req_ready  in   1     dmem accepts request
// dmem_rsp_valid  in   1     load data ready / store committed
// reg_write_en    out  1     register file write strobe
// pc              out  XLEN  current instruction PC
// trap            out  1     1-cycle pulse on trap entry
// trap_pc         out  XLEN  PC of faulting instruction (held until next trap)
// halted          out  1     core halted
// retire          out  1     1-cycle pulse per retired instruction
// retire_count    out  COUNT_W  retired instruction count
// BEHAVIOUR
// - Reset: state=BOOT; pc=RESET_VECTOR; trap_pc=0; retire_count=0; all strobes/valids/halted=0.
// - rst overrides every state and takes effect on the same edge; it may assert mid-transaction.
// - Any *_rsp_valid outside its WAIT state is ignored, including stale pre-reset responses.
// - BOOT: one idle cycle, then FETCH.
// - FETCH: imem_req_valid=1, imem_addr=pc.
//   - Handshake completes on valid&&ready; go to FETCH_WAIT.
//   - valid stays high until accepted; addr is stable while valid.
// - FETCH_WAIT: on imem_rsp_valid, pulse instr_latch_en and go to EXECUTE.
//   - A response never counts in the same cycle as its request acceptance.
// - EXECUTE: one cycle. Priority:
//   - !opcode_valid: TRAP.
//   - is_env: HALT.
//   - is_load|is_store: MEM.
//   - otherwise: WRITEBACK.
// - MEM: dmem_req_valid=1 until dmem_req_ready, then MEM_WAIT; on dmem_rsp_valid, go to WRITEBACK.
// - WRITEBACK: one cycle; retire=1; retire_count+=1 (wraps modulo 2^COUNT_W).
//   - Redirect when (is_branch&&branch_taken)||is_jump.
//   - Redirect with jump_target[1:0]!=0: no retire, no reg write; go to TRAP.
//   - Redirect otherwise: pc<=jump_target.
//   - No redirect: pc<=pc+4 (wraps modulo 2^XLEN).
//   - reg_write_en=1 unless is_store or is_branch. Rest: FETCH.
// - TRAP: one cycle; trap=1; trap_pc<=pc; pc<=TRAP_VECTOR; then FETCH. A trapping instruction never retires.
// - HALT: halted=1; no requests issued; exits only on rst.
// - Minimum latency: 4 cycles (FETCH, FETCH_WAIT, EXECUTE, WRITEBACK) with zero-wait memory; MEM adds >=2.
// TESTING
// - Zero-wait imem, 3 ALU instrs: retire every 4 cycles; pc 0 -> 4 -> 8 -> 'hC; retire_count=3.
// - imem_req_ready low 5 cycles:
//   - imem_req_valid held high with imem_addr stable.
//   - Single instr_latch_en pulse after rsp.
// - Load with dmem_rsp delayed 3 cycles: reg_write_en exactly once, after rsp.
// - Store: no reg_write_en.
// - Taken branch at pc=8, target 'h40: next imem_addr='h40.
//   - Same branch with target 'h42: trap pulse, trap_pc=8, next fetch 'h100, retire_count unchanged.
// - opcode_valid=0 at pc=4: trap, trap_pc=4.
//   - is_env: halted=1 and no further imem_req_valid for 20 cycles.
// - rst mid-MEM_WAIT, then late dmem_rsp_valid: ignored.
//   - pc=RESET_VECTOR, retire_count=0, first fetch 2 cycles after rst drops.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control sequencer. Owns the PC and walks each instruction
// through FETCH / FETCH_WAIT / EXECUTE / [MEM / MEM_WAIT] / WRITEBACK using
// valid/ready handshakes to instruction and data memory, so either memory
// may stall. Illegal opcodes and misaligned redirect targets trap to
// TRAP_VECTOR; environment instructions halt the core until reset. A retire
// counter tracks completed instructions.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_valid/ready     fetch request handshake, imem_addr = pc
//   imem_rsp_valid           fetched instruction present on imem data bus
//   instr_latch_en           pulse: external IR captures imem data
//   opcode_valid, is_*       decoder outputs (sampled in EXECUTE/WRITEBACK)
//   branch_taken,jump_target branch/jump resolution, valid in WRITEBACK
//   dmem_req_valid/ready     load/store request handshake
//   dmem_rsp_valid           load data ready / store committed
//   reg_write_en             register file write strobe
//   pc                       current instruction PC
//   trap, trap_pc            trap entry pulse, PC of faulting instruction
//   halted                   core halted
//   retire, retire_count     retire pulse and wrapping retire counter
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int unsigned        XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = 'h0,
    parameter logic [XLEN-1:0]    TRAP_VECTOR  = 'h100,
    parameter int unsigned        COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_rsp_valid,
    output logic               instr_latch_en,
    input  logic               opcode_valid,
    input  logic               is_load,
    input  logic               is_store,
    input  logic               is_branch,
    input  logic               is_jump,
    input  logic               is_env,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    jump_target,
    output logic               dmem_req_valid,
    input  logic               dmem_req_ready,
    input  logic               dmem_rsp_valid,
    output logic               reg_write_en,
    output logic [XLEN-1:0]    pc,
    output logic               trap,
    output logic [XLEN-1:0]    trap_pc,
    output logic               halted,
    output logic               retire,
    output logic [COUNT_W-1:0] retire_count
);

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_FETCH_WAIT,
        S_EXECUTE,
        S_MEM,
        S_MEM_WAIT,
        S_WRITEBACK,
        S_TRAP,
        S_HALT
    } state_t;

    state_t             r_state;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_trap_pc;
    logic [COUNT_W-1:0] r_retire_count;
    logic               r_imem_req_valid;
    logic               r_dmem_req_valid;
    logic               r_trap;
    logic               r_halted;

    logic w_redirect;
    logic w_misaligned;
    logic w_retire;

    assign w_redirect   = (is_branch && branch_taken) || is_jump;
    assign w_misaligned = w_redirect && (jump_target[1:0] != 2'b00);

    // Retire, register write and IR capture depend on same-cycle inputs
    // (redirect target, imem response), so they are decoded from the
    // registered state rather than registered themselves.
    assign w_retire       = (r_state == S_WRITEBACK) && !w_misaligned;
    assign retire         = w_retire;
    assign reg_write_en   = w_retire && !is_store && !is_branch;
    assign instr_latch_en = (r_state == S_FETCH_WAIT) && imem_rsp_valid;

    assign imem_req_valid = r_imem_req_valid;
    assign imem_addr      = r_pc;
    assign dmem_req_valid = r_dmem_req_valid;
    assign pc             = r_pc;
    assign trap           = r_trap;
    assign trap_pc        = r_trap_pc;
    assign halted         = r_halted;
    assign retire_count   = r_retire_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_BOOT;
            r_pc             <= RESET_VECTOR;
            r_trap_pc        <= '0;
            r_retire_count   <= '0;
            r_imem_req_valid <= 1'b0;
            r_dmem_req_valid <= 1'b0;
            r_trap           <= 1'b0;
            r_halted         <= 1'b0;
        end else begin
            r_trap <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state          <= S_FETCH;
                    r_imem_req_valid <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_req_ready) begin
                        r_state          <= S_FETCH_WAIT;
                        r_imem_req_valid <= 1'b0;
                    end
                end
                S_FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (!opcode_valid) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end else if (is_env) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (is_load || is_store) begin
                        r_state          <= S_MEM;
                        r_dmem_req_valid <= 1'b1;
                    end else begin
                        r_state <= S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (dmem_req_ready) begin
                        r_state          <= S_MEM_WAIT;
                        r_dmem_req_valid <= 1'b0;
                    end
                end
                S_MEM_WAIT: begin
                    if (dmem_rsp_valid) begin
                        r_state <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (w_misaligned) begin
                        // pc is left on the faulting instruction for TRAP
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end else begin
                        r_retire_count   <= r_retire_count + COUNT_W'(1);
                        r_pc             <= w_redirect ? jump_target : r_pc + XLEN'(4);
                        r_state          <= S_FETCH;
                        r_imem_req_valid <= 1'b1;
                    end
                end
                S_TRAP: begin
                    r_trap_pc        <= r_pc;
                    r_pc             <= TRAP_VECTOR;
                    r_state          <= S_FETCH;
                    r_imem_req_valid <= 1'b1;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

endmodule
